ssd_scan_ctrl: RTL and testbench

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

---
 rtl/ssd_scan_ctrl_if.sv | 38 +++
 rtl/ssd_scan_ctrl.sv | 86 ++++++++
 tb/tb_ssd_scan_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_ctrl_if
// Description : Bundles the value/blanking inputs and the scanned digit
//               outputs of the seven-segment scan controller.
//               val        - four nibbles, val[3:0] is the rightmost digit
//               blank_lz   - leading-zero blanking enable
//               bin        - nibble of the digit currently scanned
//               d          - active-low digit enables
//               frame_tick - one-cycle pulse at each frame boundary
//               master : drives val/blank_lz, observes the display outputs
//               slave  : the scan controller itself
// Revision    : 1.0 - initial release
// ============================================================================
interface ssd_scan_ctrl_if;
  logic [15:0] val;
  logic        blank_lz;
  logic [3:0]  bin;
  logic [3:0]  d;
  logic        frame_tick;

  modport master (
    output val,
    output blank_lz,
    input  bin,
    input  d,
    input  frame_tick
  );

  modport slave (
    input  val,
    input  blank_lz,
    output bin,
    output d,
    output frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_ctrl
// Description : Time-multiplexed scan controller for a four-digit seven-
//               segment display. Each digit is held for REFRESH_DIV cycles;
//               the displayed value is captured once per frame into a shadow
//               register so the display never tears mid-frame. Optional
//               leading-zero blanking switches off upper zero digits while
//               the rightmost digit is always lit.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - ssd_scan_ctrl_if.slave (val, blank_lz in;
//                      bin, d, frame_tick out, all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input wire             clk,
  input wire             rst,
  ssd_scan_ctrl_if.slave bus
);

  localparam int unsigned c_CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_idx;
  logic [15:0]        r_shadow;
  logic [3:0]         r_bin;
  logic [3:0]         r_d;
  logic               r_frame_tick;

  logic               w_step;
  logic               w_frame;
  logic [1:0]         w_idx_nxt;
  logic [15:0]        w_shadow_nxt;
  logic [15:0]        w_upper;
  logic               w_blank;
  logic [3:0]         w_bin_nxt;
  logic [3:0]         w_d_nxt;

  // Outputs are computed from the values idx/shadow will hold after the
  // step edge, so bin/d change on the same edge as idx with no extra lag.
  always_comb begin
    w_step       = (r_cnt == c_CNT_MAX);
    w_frame      = w_step && (r_idx == 2'd3);
    w_idx_nxt    = r_idx + 2'd1;
    w_shadow_nxt = w_frame ? bus.val : r_shadow;
    // Shadow shifted so the scanned nibble sits at the bottom; everything
    // left over is that digit and the digits to its left, which is exactly
    // what leading-zero blanking has to test.
    w_upper      = w_shadow_nxt >> {w_idx_nxt, 2'b00};
    w_blank      = bus.blank_lz && (w_idx_nxt != 2'd0) && (w_upper == 16'h0000);
    w_bin_nxt    = w_upper[3:0];
    w_d_nxt      = w_blank ? 4'b1111 : ~(4'b0001 << w_idx_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_shadow     <= 16'h0000;
      r_bin        <= 4'h0;
      r_d          <= 4'b1110;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame;
      if (w_step) begin
        r_cnt    <= '0;
        r_idx    <= w_idx_nxt;
        r_shadow <= w_shadow_nxt;
        r_bin    <= w_bin_nxt;
        r_d      <= w_d_nxt;
      end else begin
        r_cnt    <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  assign bus.bin        = r_bin;
  assign bus.d          = r_d;
  assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_ctrl
// Description : Self-checking bench for ssd_scan_ctrl with REFRESH_DIV=4.
//               A cycle-count based model derives the expected digit, nibble,
//               enables and frame pulse; directed sequences add literal
//               expectations for scan order, tear-free update, blanking,
//               mid-frame reset and frame timing.
// Ports       : none (top-level bench)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_ctrl;

  localparam int unsigned c_DIV   = 4;
  localparam int          c_FRAME = 4 * c_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  ssd_scan_ctrl_if ifc ();

  ssd_scan_ctrl #(.REFRESH_DIV(c_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: number of clock edges since reset release, plus the inputs as
  // they were seen at the last digit step and the last frame boundary.
  int          m_n      = 0;
  logic [15:0] m_shadow = 16'h0000;
  logic        m_blank  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n      = 0;
      m_shadow = 16'h0000;
      m_blank  = 1'b0;
    end else begin
      m_n = m_n + 1;
      if (m_n % c_DIV == 0) begin
        m_blank = ifc.blank_lz;
        if (m_n % c_FRAME == 0) m_shadow = ifc.val;
      end
    end
  end

  function automatic void model_out(output logic [3:0] eb, output logic [3:0] ed,
                                    output logic eft);
    int idx;
    bit zero;
    idx  = (m_n / c_DIV) % 4;
    eft  = (m_n >= c_FRAME) && (m_n % c_FRAME == 0);
    eb   = m_shadow[idx*4 +: 4];
    zero = 1'b1;
    for (int q = idx; q < 4; q++)
      if (m_shadow[q*4 +: 4] != 4'h0) zero = 1'b0;
    ed = (m_blank && idx != 0 && zero) ? 4'b1111 : ~(4'b0001 << idx);
  endfunction

  logic [3:0] mb, md;
  logic       mft;

  always @(negedge clk) begin
    if (mon_en) begin
      model_out(mb, md, mft);
      chk("model_bin", 32'(ifc.bin), 32'(mb));
      chk("model_d", 32'(ifc.d), 32'(md));
      chk("model_tick", 32'(ifc.frame_tick), 32'(mft));
      chk("d_one_low", 32'($countones(~ifc.d) <= 1), 32'd1);
    end
  end

  // Counts negedges until frame_tick is seen; bounded.
  task automatic count_to_tick(input string nm, input int exp_cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ifc.frame_tick !== 1'b1 && n < 4 * c_FRAME);
    chk(nm, 32'(n), 32'(exp_cycles));
  endtask

  // Called on the first cycle of a frame; checks each digit once, ends on
  // the first cycle of the next frame.
  task automatic check_frame(input string nm, input logic [15:0] eb, input logic [15:0] ed);
    chk({nm, "_tick"}, 32'(ifc.frame_tick), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk({nm, "_bin"}, 32'(ifc.bin), 32'(eb[k*4 +: 4]));
      chk({nm, "_d"}, 32'(ifc.d), 32'(ed[k*4 +: 4]));
      repeat (c_DIV) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    ifc.val      = 16'h1234;
    ifc.blank_lz = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;

    // Reset state with the clock running
    repeat (3) begin
      @(negedge clk);
      chk("rst_d", 32'(ifc.d), 32'h0000000E);
      chk("rst_bin", 32'(ifc.bin), 32'h0);
      chk("rst_tick", 32'(ifc.frame_tick), 32'h0);
    end
    #1 rst = 1'b0;
    count_to_tick("first_tick_cycle", 16);

    // Scan order, two frames
    check_frame("scan1", 16'h1234, 16'h7BDE);
    check_frame("scan2", 16'h1234, 16'h7BDE);

    // Tear-free: new value mid-frame only shows up next frame
    repeat (c_DIV) @(negedge clk);
    ifc.val = 16'hABCD;
    repeat (c_DIV) @(negedge clk);
    chk("tear_bin2", 32'(ifc.bin), 32'h2);
    chk("tear_d2", 32'(ifc.d), 32'hB);
    repeat (c_DIV) @(negedge clk);
    chk("tear_bin3", 32'(ifc.bin), 32'h1);
    chk("tear_d3", 32'(ifc.d), 32'h7);
    repeat (c_DIV) @(negedge clk);
    check_frame("abcd", 16'hABCD, 16'h7BDE);

    // Leading-zero blanking
    ifc.val      = 16'h0050;
    ifc.blank_lz = 1'b1;
    count_to_tick("tick_blank", 16);
    check_frame("blank50", 16'h0050, 16'hFFDE);
    ifc.val = 16'h0000;
    count_to_tick("tick_zero", 16);
    check_frame("blank00", 16'h0000, 16'hFFFE);

    // Asynchronous reset while digit 2 is scanned
    ifc.val      = 16'h1234;
    ifc.blank_lz = 1'b0;
    repeat (2 * c_DIV) @(negedge clk);
    chk("pre_rst_d", 32'(ifc.d), 32'hB);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_d", 32'(ifc.d), 32'hE);
    chk("async_rst_bin", 32'(ifc.bin), 32'h0);
    chk("async_rst_tick", 32'(ifc.frame_tick), 32'h0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (ifc.frame_tick !== 1'b1) chk("post_rst_bin_zero", 32'(ifc.bin), 32'h0);
    end while (ifc.frame_tick !== 1'b1 && n < 4 * c_FRAME);
    chk("post_rst_tick_cycle", 32'(n), 32'd16);
    chk("post_rst_bin_loaded", 32'(ifc.bin), 32'h4);

    // Ten frames of pulse width and period
    for (int f = 0; f < 10; f++) begin
      @(negedge clk);
      chk("tick_width", 32'(ifc.frame_tick), 32'h0);
      n = 1;
      while (ifc.frame_tick !== 1'b1 && n < 4 * c_FRAME) begin
        @(negedge clk);
        n++;
      end
      chk("tick_period", 32'(n), 32'd16);
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
